// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel input path: button indices,
// bus widths, the key-operation encoding and a priority helper.
package panel_pkg;

  localparam int NUM_BTN    = 5;
  localparam int NUM_SW     = 16;
  localparam int HEX_W      = 32;
  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = HEX_W / DIGIT_W;

  localparam int BTN_STEP = 0;
  localparam int BTN_CONT = 1;
  localparam int BTN_CHK  = 2;
  localparam int BTN_ENT  = 3;
  localparam int BTN_DEL  = 4;

  // What the hex-entry register does on a given cycle.
  typedef enum logic [1:0] {
    KEY_NONE  = 2'd0,
    KEY_DIGIT = 2'd1,
    KEY_DEL   = 2'd2,
    KEY_CLEAR = 2'd3
  } key_op_e;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [DIGIT_W-1:0] lowest_set(input logic [NUM_SW-1:0] bits);
    lowest_set = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (bits[i]) lowest_set = DIGIT_W'(i);
    end
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// Two-flop synchronizer followed by a HIST-deep sample filter. Samples are
// taken only on the shared tick; a bit flips once the newest HIST samples
// all agree on the opposite level.
module panel_debounce #(
  parameter int WIDTH = 1,
  parameter int HIST  = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  logic [WIDTH-1:0]            sync1_q;
  logic [WIDTH-1:0]            sync2_q;
  logic [HIST-1:0][WIDTH-1:0]  hist_q;
  logic [HIST-1:0][WIDTH-1:0]  hist_d;
  logic [WIDTH-1:0]            stable_q;
  logic [WIDTH-1:0]            stable_d;
  logic [WIDTH-1:0]            all_hi;
  logic [WIDTH-1:0]            all_lo;

  // Metastability guard: raw pins are only seen through two flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Shift a new synchronized sample into the history on each tick; index 0 is newest.
  always_comb begin
    hist_d = hist_q;
    if (tick) hist_d = {hist_q[HIST-2:0], sync2_q};
  end

  // Per bit, detect whether every retained sample is high or every one is low.
  always_comb begin
    all_hi = '1;
    all_lo = '1;
    for (int h = 0; h < HIST; h++) begin
      all_hi = all_hi & hist_d[h];
      all_lo = all_lo & ~hist_d[h];
    end
  end

  // Adopt a unanimous level on the tick; otherwise keep the current level.
  always_comb begin
    stable_d = stable_q;
    if (tick) stable_d = (stable_q | all_hi) & ~all_lo;
  end

  // History and filtered-level registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q   <= '0;
      stable_q <= '0;
    end else begin
      hist_q   <= hist_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/panel_input.sv
// Front-panel input block: debounces 5 buttons and 16 hex switches with a
// shared sample tick, turns button presses into one-cycle pulses and turns
// switch changes into hex-digit entry with a delete key.
// Optional build macro PANEL_AUTOCLR_EN: the ent key clears the entered
// value on the cycle after its pulse.
module panel_input
  import panel_pkg::*;
#(
  parameter int DEB_CYCLES = 100000,
  parameter int HIST       = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_SW-1:0]  sw_raw,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_SW-1:0]  sw_stable,
  output logic [HEX_W-1:0]   hex_val,
  output logic [3:0]         digit_cnt,
  output logic               key_event
);

  localparam int                TICK_W    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEB_CYCLES - 1);
  localparam logic [3:0]        CNT_MAX   = 4'(MAX_DIGITS);

  logic [TICK_W-1:0]  tick_cnt_q;
  logic [TICK_W-1:0]  tick_cnt_d;
  logic               tick;

  logic [NUM_BTN-1:0] btn_stable;
  logic [NUM_BTN-1:0] btn_last_q;
  logic [NUM_BTN-1:0] btn_last_d;
  logic [NUM_SW-1:0]  sw_last_q;
  logic [NUM_SW-1:0]  sw_last_d;
  logic [NUM_SW-1:0]  sw_change;
  logic [DIGIT_W-1:0] digit;

  key_op_e            key_op;
  logic [HEX_W-1:0]   hex_q;
  logic [HEX_W-1:0]   hex_d;
  logic [3:0]         cnt_q;
  logic [3:0]         cnt_d;
  logic               key_q;
  logic               key_d;

  // Free-running sample-rate divider; the tick fires on the wrap cycle.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Divider register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  panel_debounce #(
    .WIDTH (NUM_BTN),
    .HIST  (HIST)
  ) u_btn_deb (
    .clk    (clk),
    .rstn   (rstn),
    .tick   (tick),
    .raw    (btn_raw),
    .stable (btn_stable)
  );

  panel_debounce #(
    .WIDTH (NUM_SW),
    .HIST  (HIST)
  ) u_sw_deb (
    .clk    (clk),
    .rstn   (rstn),
    .tick   (tick),
    .raw    (sw_raw),
    .stable (sw_stable)
  );

  // Edge detection: press pulses for buttons, any-direction changes for switches.
  always_comb begin
    btn_last_d = btn_stable;
    sw_last_d  = sw_stable;
    btn_pulse  = btn_stable & ~btn_last_q;
    sw_change  = sw_stable ^ sw_last_q;
    digit      = lowest_set(sw_change);
  end

  // Previous-cycle copies of the debounced levels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_last_q <= '0;
      sw_last_q  <= '0;
    end else begin
      btn_last_q <= btn_last_d;
      sw_last_q  <= sw_last_d;
    end
  end

  // Pick this cycle's operation: digit entry beats clear, clear beats delete.
  always_comb begin
    key_op = KEY_NONE;
    if (|sw_change) begin
      key_op = KEY_DIGIT;
    end
`ifdef PANEL_AUTOCLR_EN
    else if (btn_pulse[BTN_ENT]) begin
      key_op = KEY_CLEAR;
    end
`endif
    else if (btn_pulse[BTN_DEL]) begin
      key_op = KEY_DEL;
    end
  end

  // Apply the operation to the digit shift register and its saturating count.
  always_comb begin
    hex_d = hex_q;
    cnt_d = cnt_q;
    key_d = 1'b0;
    unique case (key_op)
      KEY_DIGIT: begin
        hex_d = {hex_q[HEX_W-DIGIT_W-1:0], digit};
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
        key_d = 1'b1;
      end
      KEY_DEL: begin
        hex_d = {{DIGIT_W{1'b0}}, hex_q[HEX_W-1:DIGIT_W]};
        cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
        key_d = 1'b1;
      end
      KEY_CLEAR: begin
        hex_d = '0;
        cnt_d = '0;
      end
      default: begin
      end
    endcase
  end

  // Entered value, digit count and key-event registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hex_q <= '0;
      cnt_q <= '0;
      key_q <= 1'b0;
    end else begin
      hex_q <= hex_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  end

  assign hex_val   = hex_q;
  assign digit_cnt = cnt_q;
  assign key_event = key_q;

endmodule

// File: tb/tb_panel_input.sv
// Self-checking bench for panel_input with DEB_CYCLES=4, HIST=3.
// A behavioural model (sample queues, majority counts, integer shifts)
// is stepped every clock and compared against all outputs; a vector table
// and hand sequences cover digit entry, delete, saturation, glitches,
// reset and the optional PANEL_AUTOCLR_EN behaviour.
`timescale 1ns/1ps
module tb_panel_input;
  import panel_pkg::*;

  localparam int DEB = 4;
  localparam int HST = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  btn_raw = '0;
  logic [15:0] sw_raw = '0;
  logic [4:0]  btn_pulse;
  logic [15:0] sw_stable;
  logic [31:0] hex_val;
  logic [3:0]  digit_cnt;
  logic        key_event;

  always #5 clk = ~clk;

  panel_input #(.DEB_CYCLES(DEB), .HIST(HST)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .btn_raw   (btn_raw),
    .sw_raw    (sw_raw),
    .btn_pulse (btn_pulse),
    .sw_stable (sw_stable),
    .hex_val   (hex_val),
    .digit_cnt (digit_cnt),
    .key_event (key_event)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state
  logic [20:0] rawQ[$];
  logic [20:0] smp[HST];
  logic [20:0] curSt;
  logic [20:0] lastSt;
  logic [31:0] mHex;
  int          mCnt;
  logic        mKey;
  int          edgeN;

  // Observation counters
  int          cycNum = 0;
  int          keyCount = 0;
  int          pulseCount[5];
  int          firstPulseCyc = -1;
  logic [15:0] swState = '0;

  typedef struct {
    logic [15:0] swToggle;
    logic [4:0]  btnPress;
    logic [31:0] expHex;
    int          expCnt;
    int          expKeys;
  } vec_t;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycNum);
    end
  endtask

  task automatic resetModel();
    rawQ.delete();
    for (int h = 0; h < HST; h++) smp[h] = '0;
    curSt  = '0;
    lastSt = '0;
    mHex   = '0;
    mCnt   = 0;
    mKey   = 1'b0;
    edgeN  = 0;
  endtask

  // One clock edge of the reference model, using the inputs present at that edge.
  task automatic modelEdge();
    logic [20:0] syncVal;
    logic [20:0] nxt;
    logic [15:0] swChg;
    logic [4:0]  pulses;
    int          k;
    syncVal = (rawQ.size() >= 2) ? rawQ[rawQ.size()-2] : 21'h0;
    rawQ.push_back({sw_raw, btn_raw});
    if (rawQ.size() > 2) void'(rawQ.pop_front());

    swChg  = curSt[20:5] ^ lastSt[20:5];
    pulses = curSt[4:0] & ~lastSt[4:0];
    mKey   = 1'b0;
    if (swChg != 16'h0) begin
      k = 0;
      while (!swChg[k]) k++;
      mHex = (mHex << 4) | 32'(k);
      if (mCnt < 8) mCnt++;
      mKey = 1'b1;
    end
`ifdef PANEL_AUTOCLR_EN
    else if (pulses[BTN_ENT]) begin
      mHex = '0;
      mCnt = 0;
    end
`endif
    else if (pulses[BTN_DEL]) begin
      mHex = mHex >> 4;
      if (mCnt > 0) mCnt--;
      mKey = 1'b1;
    end

    nxt = curSt;
    if (edgeN % DEB == DEB - 1) begin
      for (int h = HST - 1; h > 0; h--) smp[h] = smp[h-1];
      smp[0] = syncVal;
      for (int b = 0; b < 21; b++) begin
        int ones;
        ones = 0;
        for (int h = 0; h < HST; h++) ones += int'(smp[h][b]);
        if (ones == HST) nxt[b] = 1'b1;
        else if (ones == 0) nxt[b] = 1'b0;
      end
    end
    edgeN++;
    lastSt = curSt;
    curSt  = nxt;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (!rstn) resetModel();
    else modelEdge();
    cycNum++;
    checkOutput("btn_pulse", 32'(btn_pulse), 32'(curSt[4:0] & ~lastSt[4:0]));
    checkOutput("sw_stable", 32'(sw_stable), 32'(curSt[20:5]));
    checkOutput("hex_val",   hex_val, mHex);
    checkOutput("digit_cnt", 32'(digit_cnt), 32'(mCnt));
    checkOutput("key_event", 32'(key_event), 32'(mKey));
    if (key_event) keyCount++;
    for (int i = 0; i < 5; i++) if (btn_pulse[i]) pulseCount[i]++;
    if (btn_pulse[0] && firstPulseCyc < 0) firstPulseCyc = cycNum;
  endtask

  task automatic applyStimulus(input logic [4:0] btn, input logic [15:0] sw, input int n);
    btn_raw = btn;
    sw_raw  = sw;
    repeat (n) stepCycle();
  endtask

  task automatic clearCounts();
    keyCount = 0;
    firstPulseCyc = -1;
    for (int i = 0; i < 5; i++) pulseCount[i] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          startCyc;
    int          lat;
    logic [31:0] expHex;
    int          expCnt;
    logic        found;
    logic [15:0] s;
    logic [4:0]  b;

    resetModel();
    clearCounts();

    // Reset state
    repeat (3) stepCycle();
    checkOutput("reset_hex", hex_val, 32'h0);
    checkOutput("reset_cnt", 32'(digit_cnt), 32'h0);
    checkOutput("reset_pulse", 32'(btn_pulse), 32'h0);
    rstn = 1'b1;

    // Button press: one pulse inside the sync + 3 tick window, nothing on release
    clearCounts();
    startCyc = cycNum;
    applyStimulus(5'b00001, 16'h0, 20);
    lat = firstPulseCyc - startCyc;
    $display("[TB] step press latency %0d cycles", lat);
    checkOutput("btn0_press_pulses", 32'(pulseCount[0]), 32'd1);
    checkOutput("btn0_latency_window", 32'(firstPulseCyc > 0 && lat >= 11 && lat <= 14), 32'd1);
    checkOutput("btn0_no_key", 32'(keyCount), 32'd0);
    clearCounts();
    applyStimulus(5'b00000, 16'h0, 30);
    checkOutput("btn0_release_pulses", 32'(pulseCount[0]), 32'd0);

    // Short glitch on a switch never propagates
    clearCounts();
    applyStimulus(5'b0, 16'h0020, 6);
    applyStimulus(5'b0, 16'h0000, 30);
    checkOutput("glitch_sw_stable", 32'(sw_stable), 32'h0);
    checkOutput("glitch_hex", hex_val, 32'h0);
    checkOutput("glitch_keys", 32'(keyCount), 32'd0);

    // Vector table
    vecs.push_back('{16'h0002, 5'b00000, 32'h00000001, 1, 1});
    vecs.push_back('{16'h0004, 5'b00000, 32'h00000012, 2, 1});
    vecs.push_back('{16'h0400, 5'b00000, 32'h0000012A, 3, 1});
    vecs.push_back('{16'h0000, 5'b10000, 32'h00000012, 2, 1});
    vecs.push_back('{16'h0000, 5'b10000, 32'h00000001, 1, 1});
    vecs.push_back('{16'h0000, 5'b10000, 32'h00000000, 0, 1});
    vecs.push_back('{16'h0000, 5'b10000, 32'h00000000, 0, 1});
    vecs.push_back('{16'h0000, 5'b00001, 32'h00000000, 0, 0});
    vecs.push_back('{16'h0000, 5'b01000, 32'h00000000, 0, 0});
    expHex = 32'h0;
    expCnt = 0;
    for (int d = 1; d <= 9; d++) begin
      expHex = (expHex << 4) | 32'(d);
      if (expCnt < 8) expCnt++;
      vecs.push_back('{16'(1) << d, 5'b00000, expHex, expCnt, 1});
    end
    vecs.push_back('{16'h0088, 5'b00000, 32'h34567893, 8, 1});
    vecs.push_back('{16'h0000, 5'b10000, 32'h03456789, 7, 1});

    foreach (vecs[i]) begin
      clearCounts();
      if (vecs[i].swToggle != 16'h0) begin
        swState ^= vecs[i].swToggle;
        applyStimulus(5'b0, swState, 24);
      end else begin
        applyStimulus(vecs[i].btnPress, swState, 24);
        applyStimulus(5'b0, swState, 24);
      end
      checkOutput($sformatf("vec%0d_hex", i), hex_val, vecs[i].expHex);
      checkOutput($sformatf("vec%0d_cnt", i), 32'(digit_cnt), 32'(vecs[i].expCnt));
      checkOutput($sformatf("vec%0d_keys", i), 32'(keyCount), 32'(vecs[i].expKeys));
    end

    // Reset in the middle of a debounce clears every output at once
    applyStimulus(5'b00001, swState ^ 16'h0100, 6);
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_hex", hex_val, 32'h0);
    checkOutput("async_rst_cnt", 32'(digit_cnt), 32'h0);
    checkOutput("async_rst_sw", 32'(sw_stable), 32'h0);
    checkOutput("async_rst_pulse", 32'(btn_pulse), 32'h0);
    checkOutput("async_rst_key", 32'(key_event), 32'h0);
    swState = 16'h0001;
    applyStimulus(5'b0, swState, 2);

    // Switch already high at release becomes an ordinary digit-0 entry
    clearCounts();
    rstn = 1'b1;
    applyStimulus(5'b0, swState, 24);
    checkOutput("sw_high_at_reset_cnt", 32'(digit_cnt), 32'd1);
    checkOutput("sw_high_at_reset_hex", hex_val, 32'h0);
    checkOutput("sw_high_at_reset_keys", 32'(keyCount), 32'd1);

    // Build 0xABC then press ent
    swState ^= 16'h0400; applyStimulus(5'b0, swState, 24);
    swState ^= 16'h0800; applyStimulus(5'b0, swState, 24);
    swState ^= 16'h1000; applyStimulus(5'b0, swState, 24);
    checkOutput("abc_hex", hex_val, 32'h00000ABC);
    checkOutput("abc_cnt", 32'(digit_cnt), 32'd4);
    btn_raw = 5'b01000;
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      stepCycle();
      if (btn_pulse[BTN_ENT]) found = 1'b1;
    end
    checkOutput("ent_pulse_seen", 32'(found), 32'd1);
    if (found) begin
      checkOutput("ent_hold_hex", hex_val, 32'h00000ABC);
      stepCycle();
`ifdef PANEL_AUTOCLR_EN
      checkOutput("ent_after_hex", hex_val, 32'h0);
      checkOutput("ent_after_cnt", 32'(digit_cnt), 32'd0);
`else
      checkOutput("ent_after_hex", hex_val, 32'h00000ABC);
      checkOutput("ent_after_cnt", 32'(digit_cnt), 32'd4);
`endif
      checkOutput("ent_after_key", 32'(key_event), 32'd0);
    end
    applyStimulus(5'b0, swState, 24);

    // Randomized traffic against the model
    for (int it = 0; it < 250; it++) begin
      s = swState ^ (16'(1) << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) s ^= 16'(1) << $urandom_range(0, 15);
      swState = s;
      b = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
      applyStimulus(b, swState, int'($urandom_range(1, 20)));
    end
    applyStimulus(5'b0, swState, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/panel_input.md
PANEL_INPUT -- requirements
Module: panel_input

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 100000, clk cycles per debounce sample tick (min 2).
REQ-002 SHALL have parameter HIST, default 3, consecutive agreeing samples needed to accept a new level (2..4).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rstn  input  1  reset; reset rstn, asynchronous, active-low; clock clk.
REQ-005 SHALL have port btn_raw  input  5  raw buttons, active-high; bit 0 step, 1 cont, 2 chk, 3 ent, 4 del.
REQ-006 SHALL have port sw_raw  input  16  raw hex-entry switches.
REQ-007 SHALL have port btn_pulse  output  5  one-cycle pulse per debounced button press, same bit order.
REQ-008 SHALL have port sw_stable  output  16  debounced switch levels.
REQ-009 SHALL have port hex_val  output  32  entered hex value; digit 0 in bits [3:0].
REQ-010 SHALL have port digit_cnt  output  4  digits currently entered, 0..8.
REQ-011 SHALL have port key_event  output  1  one-cycle pulse on each accepted digit or delete.

Function
REQ-012 SHALL pass every raw bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL run one free tick counter, 0..DEB_CYCLES-1, shared by all 21 inputs; sampling occurs when the counter wraps.
REQ-014 SHALL update a debounced bit on a tick when the last HIST samples agree with each other and differ from the current level.
REQ-015 SHALL make the update visible in the cycle after that tick; glitches shorter than HIST-1 ticks never propagate.
REQ-016 SHALL assert btn_pulse[i] for exactly one clk on a 0->1 transition of debounced button i; releases produce nothing.
REQ-017 SHALL treat any debounced change of sw_stable bit k, in either direction, as entry of hex digit k.
REQ-018 SHALL take the lowest-numbered bit when several switch bits change in one cycle; the others are discarded.
REQ-019 SHALL apply digit entry as hex_val <= {hex_val[27:0], k}, with digit_cnt incremented and saturating at 8.
REQ-020 SHALL apply a del pulse as hex_val <= {4'h0, hex_val[31:4]}, with digit_cnt decremented and saturating at 0.
REQ-021 SHALL give digit entry priority when entry and del occur in the same cycle; that del is dropped.
REQ-022 SHALL update hex_val/digit_cnt one cycle after the debounced change and pulse key_event in that same cycle.
REQ-023 SHALL, on an entry at digit_cnt=8, shift the top digit out and keep digit_cnt at 8.
REQ-024 SHALL, on del at digit_cnt=0, keep hex_val at 0 and still pulse key_event.

Reset
REQ-025 SHALL asynchronously clear, while rstn is low: synchronizers, sample histories, tick counter, sw_stable, btn_pulse, hex_val, digit_cnt and key_event.
REQ-026 SHALL raise no pulse from a switch already high at reset release; it is accepted as a normal digit-entry change after HIST ticks.

Configuration
REQ-027 SHALL support macro PANEL_AUTOCLR_EN.
REQ-028 SHALL, with PANEL_AUTOCLR_EN defined, hold hex_val unchanged during the ent pulse cycle and clear hex_val and digit_cnt to 0 in the following cycle, with no key_event.
REQ-029 SHALL, with PANEL_AUTOCLR_EN defined, give a digit entry in that same clear cycle priority over the clear.
REQ-030 SHALL, without PANEL_AUTOCLR_EN, leave hex_val unaffected by ent.

Structure
REQ-031 SHALL place BTN_STEP/BTN_CONT/BTN_CHK/BTN_ENT/BTN_DEL indices, NUM_BTN=5, NUM_SW=16 and HEX_W=32 in shared package panel_pkg.
REQ-032 SHALL implement synchronizer plus HIST-sample filter as sub-module panel_debounce, parameterized by width and fed the shared tick.

Verification (DEB_CYCLES=4, HIST=3)
REQ-033 SHALL verify: btn_raw[0] held high 20 cycles -> exactly one btn_pulse[0], arriving 2 sync cycles plus at most 3 ticks after the rise; none on release.
REQ-034 SHALL verify: sw_raw[5] glitch high for 6 cycles -> sw_stable, hex_val and key_event unchanged.
REQ-035 SHALL verify: toggle sw bits 1, 2, 10 in sequence -> hex_val=32'h0000012A, digit_cnt=3, three key_event pulses.
REQ-036 SHALL verify: hex_val=32'h0000012A, then del twice -> 32'h00000001, digit_cnt=1; then del twice more -> 0, digit_cnt=0, two key_events.
REQ-037 SHALL verify: 9 digits 1..9 -> hex_val=32'h23456789, digit_cnt=8; bits 3 and 7 changing together -> digit 3 only.
REQ-038 SHALL verify: with PANEL_AUTOCLR_EN, ent at hex_val=32'h00000ABC -> value held during the pulse cycle, 0 next cycle; rstn low mid-debounce -> all outputs 0 immediately.
